// File: rtl/alu_chain_seq_if.sv
// Signal bundle between the host, the chain sequencer and the ALU stage: command in, ALU issue/result, chain result out.
// slave is the sequencer's view; master is the surrounding environment's view.
interface alu_chain_seq_if #(
  parameter int XLEN = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_mode;
  logic [1:0]      cmd_sel;
  logic [XLEN-1:0] cmd_arg1;
  logic [XLEN-1:0] cmd_arg2;
  logic            cmd_last;

  logic            alu_valid;
  logic            alu_ready;
  logic [3:0]      alu_mode;
  logic [XLEN-1:0] alu_arg1;
  logic [XLEN-1:0] alu_arg2;
  logic            alu_rvalid;
  logic            alu_rready;
  logic [XLEN-1:0] alu_result;

  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_sel, cmd_arg1, cmd_arg2, cmd_last,
    input  alu_ready, alu_rvalid, alu_result, res_ready,
    output cmd_ready, alu_valid, alu_mode, alu_arg1, alu_arg2, alu_rready,
    output res_valid, res_data
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_sel, cmd_arg1, cmd_arg2, cmd_last,
    output alu_ready, alu_rvalid, alu_result, res_ready,
    input  cmd_ready, alu_valid, alu_mode, alu_arg1, alu_arg2, alu_rready,
    input  res_valid, res_data
  );
endinterface

// File: rtl/alu_chain_seq.sv
// Buffers ALU commands and issues one at a time with accumulator substitution; accept-to-issue 1 cycle, 1 op / 2 cycles.
// Stalls ALU results when a finished chain result is unconsumed; ALU_CHAIN_SEQ_STATS_EN adds stat_ops/stat_chains counters.
module alu_chain_seq #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  alu_chain_seq_if.slave     io
`ifdef ALU_CHAIN_SEQ_STATS_EN
  ,
  output logic [31:0]        stat_ops,
  output logic [31:0]        stat_chains
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]      mode;
    logic [1:0]      sel;
    logic [XLEN-1:0] arg1;
    logic [XLEN-1:0] arg2;
    logic            last;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  cmd_t            mem_q [DEPTH];
  cmd_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [XLEN-1:0] acc_q, acc_d, res_data_q, res_data_d;
  logic            busy_last_q, busy_last_d;
  logic            res_valid_q, res_valid_d;
  cmd_t            head, cmd_in;
  logic            push, pop, rsp;

  assign head   = mem_q[rd_ptr_q];
  assign cmd_in = {io.cmd_mode, io.cmd_sel, io.cmd_arg1, io.cmd_arg2, io.cmd_last};

  assign io.cmd_ready  = reset && (count_q < (AW+1)'(DEPTH));
  assign io.alu_valid  = reset && (state_q == ISSUE);
  // Hold a final result in the ALU slot while the previous chain result is still unread.
  assign io.alu_rready = reset && (state_q == WAIT) && !(busy_last_q && res_valid_q && !io.res_ready);
  assign io.alu_mode   = head.mode;
  assign io.alu_arg1   = head.sel[0] ? acc_q : head.arg1;
  assign io.alu_arg2   = head.sel[1] ? acc_q : head.arg2;
  assign io.res_valid  = reset && res_valid_q;
  assign io.res_data   = reset ? res_data_q : '0;

  assign push = io.cmd_valid && io.cmd_ready;
  assign pop  = io.alu_valid && io.alu_ready;
  assign rsp  = io.alu_rvalid && io.alu_rready;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    busy_last_d = busy_last_q;
    res_valid_d = res_valid_q;

    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (res_valid_q && io.res_ready) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_d != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (pop) begin
          busy_last_d = head.last;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (rsp) begin
          acc_d = io.alu_result;
          if (busy_last_q) begin
            res_data_d  = io.alu_result;
            res_valid_d = 1'b1;
            acc_d       = '0;
          end
          state_d = (count_d != '0) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      busy_last_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      busy_last_q <= busy_last_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef ALU_CHAIN_SEQ_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d, stat_chains_q, stat_chains_d;

  always_comb begin
    stat_ops_d    = stat_ops_q + 32'(pop);
    stat_chains_d = stat_chains_q + 32'(res_valid_q && io.res_ready);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_ops_q    <= '0;
      stat_chains_q <= '0;
    end else begin
      stat_ops_q    <= stat_ops_d;
      stat_chains_q <= stat_chains_d;
    end
  end

  assign stat_ops    = stat_ops_q;
  assign stat_chains = stat_chains_q;
`endif
endmodule

// File: tb/tb_alu_chain_seq.sv
// Directed bench for alu_chain_seq with a one-slot registered ALU model (0=ADD 1=SUB 2=SLL 3=OR).
module tb_alu_chain_seq;
  logic clock;
  logic reset;
  logic alu_ready_en;
  int   checks;
  int   errors;
  logic [31:0] issued_a1[$];
  logic [31:0] res_log[$];

  alu_chain_seq_if #(.XLEN(32)) io();

`ifdef ALU_CHAIN_SEQ_STATS_EN
  logic [31:0] stat_ops, stat_chains;
  alu_chain_seq #(.XLEN(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .io(io),
    .stat_ops(stat_ops), .stat_chains(stat_chains)
  );
`else
  alu_chain_seq #(.XLEN(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .io(io)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] alu_f(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign io.alu_ready = alu_ready_en && (!io.alu_rvalid || io.alu_rready);

  always @(posedge clock) begin
    if (!reset) begin
      io.alu_rvalid <= 1'b0;
      io.alu_result <= '0;
    end else if (io.alu_valid && io.alu_ready) begin
      io.alu_rvalid <= 1'b1;
      io.alu_result <= alu_f(io.alu_mode, io.alu_arg1, io.alu_arg2);
    end else if (io.alu_rvalid && io.alu_rready) begin
      io.alu_rvalid <= 1'b0;
    end
  end

  always @(posedge clock) begin
    if (reset && io.alu_valid && io.alu_ready) issued_a1.push_back(io.alu_arg1);
    if (reset && io.res_valid && io.res_ready) res_log.push_back(io.res_data);
  end

  task automatic push_cmd(input logic [3:0] m, input logic [1:0] s, input logic [31:0] a1,
                          input logic [31:0] a2, input logic l);
    int n = 0;
    io.cmd_valid = 1'b1; io.cmd_mode = m; io.cmd_sel = s;
    io.cmd_arg1 = a1; io.cmd_arg2 = a2; io.cmd_last = l;
    while (!io.cmd_ready && n < 100) begin @(posedge clock); #1; n++; end
    if (!io.cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", io.cmd_ready);
    end
    @(posedge clock); #1;
    io.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!io.res_valid && n < 100) begin @(posedge clock); #1; n++; end
  endtask

  task automatic wait_log(input int k);
    int n = 0;
    while (res_log.size() < k && n < 200) begin @(posedge clock); #1; n++; end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (io.alu_valid !== 1'b0) begin errors++; $display("FAIL rst_alu_valid: got %b want 0", io.alu_valid); end
    checks++; if (io.alu_rready !== 1'b0) begin errors++; $display("FAIL rst_alu_rready: got %b want 0", io.alu_rready); end
    checks++; if (io.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", io.cmd_ready); end
    checks++; if (io.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b want 0", io.res_valid); end
    checks++; if (io.res_data !== 32'd0) begin errors++; $display("FAIL rst_res_data: got %0d want 0", io.res_data); end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (io.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready: got %b want 1", io.cmd_ready); end
  endtask

  task automatic test_single_chain;
    int n;
    res_log.delete();
    io.res_ready = 1'b1;
    push_cmd(4'd0, 2'b00, 32'd5, 32'd7, 1'b1);
    checks++; if (io.alu_valid !== 1'b1) begin errors++; $display("FAIL issue_latency: alu_valid=%b want 1", io.alu_valid); end
    wait_res(n);
    checks++; if (n != 2) begin errors++; $display("FAIL res_latency: got %0d cycles want 2", n); end
    checks++; if (io.res_data !== 32'd12) begin errors++; $display("FAIL single_res: got %0d want 12", io.res_data); end
    // acc must be back to 0: acc + 5 yields 5
    push_cmd(4'd0, 2'b01, 32'd99, 32'd5, 1'b1);
    wait_res(n);
    checks++; if (io.res_data !== 32'd5) begin errors++; $display("FAIL acc_cleared: got %0d want 5", io.res_data); end
    @(posedge clock); #1;
    checks++; if (io.res_valid !== 1'b0) begin errors++; $display("FAIL res_consumed: res_valid=%b want 0", io.res_valid); end
  endtask

  task automatic run_dep_chain;
    push_cmd(4'd0, 2'b00, 32'd3, 32'd4, 1'b0);
    push_cmd(4'd2, 2'b01, 32'hdead, 32'd2, 1'b0);
    push_cmd(4'd1, 2'b01, 32'hbeef, 32'd8, 1'b1);
  endtask

  task automatic test_dependent_chain;
    int n;
    issued_a1.delete(); res_log.delete();
    io.res_ready = 1'b1;
    run_dep_chain();
    wait_res(n);
    checks++; if (io.res_data !== 32'd20) begin errors++; $display("FAIL dep_res: got %0d want 20", io.res_data); end
    repeat (6) @(posedge clock);
    #1;
    checks++; if (res_log.size() != 1) begin errors++; $display("FAIL dep_count: got %0d results want 1", res_log.size()); end
    checks++; if (issued_a1.size() != 3) begin errors++; $display("FAIL dep_issues: got %0d want 3", issued_a1.size()); end
    else begin
      checks++; if (issued_a1[1] !== 32'd7) begin errors++; $display("FAIL dep_arg1_op2: got %0d want 7", issued_a1[1]); end
      checks++; if (issued_a1[2] !== 32'd28) begin errors++; $display("FAIL dep_arg1_op3: got %0d want 28", issued_a1[2]); end
    end
  endtask

  task automatic test_full_fifo;
    res_log.delete();
    io.res_ready = 1'b1;
    alu_ready_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(4'd0, 2'b00, 32'(i), 32'(i), 1'b1);
    io.cmd_valid = 1'b1; io.cmd_mode = 4'd0; io.cmd_sel = 2'b00;
    io.cmd_arg1 = 32'd5; io.cmd_arg2 = 32'd5; io.cmd_last = 1'b1;
    checks++; if (io.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %b want 0", io.cmd_ready); end
    checks++; if (io.alu_valid !== 1'b1 || io.alu_arg1 !== 32'd1) begin
      errors++; $display("FAIL stall_hold: alu_valid=%b arg1=%0d want 1/1", io.alu_valid, io.alu_arg1);
    end
    alu_ready_en = 1'b1;
    @(posedge clock); #1;
    checks++; if (io.cmd_ready !== 1'b1) begin errors++; $display("FAIL reassert_cmd_ready: got %b want 1", io.cmd_ready); end
    @(posedge clock); #1;
    io.cmd_valid = 1'b0;
    wait_log(5);
    checks++; if (res_log.size() != 5) begin errors++; $display("FAIL full_count: got %0d want 5", res_log.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (res_log[i] !== 32'(2 * (i + 1))) begin
          errors++; $display("FAIL full_res%0d: got %0d want %0d", i, res_log[i], 2 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    res_log.delete();
    io.res_ready = 1'b0;
    push_cmd(4'd0, 2'b00, 32'd1, 32'd1, 1'b1);
    push_cmd(4'd0, 2'b00, 32'd2, 32'd2, 1'b1);
    wait_res(n);
    checks++; if (io.res_data !== 32'd2) begin errors++; $display("FAIL bp_first: got %0d want 2", io.res_data); end
    repeat (6) @(posedge clock);
    #1;
    checks++; if (io.res_data !== 32'd2 || io.res_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: data=%0d valid=%b want 2/1", io.res_data, io.res_valid);
    end
    checks++; if (io.alu_rvalid !== 1'b1 || io.alu_rready !== 1'b0) begin
      errors++; $display("FAIL bp_alu_stall: rvalid=%b rready=%b want 1/0", io.alu_rvalid, io.alu_rready);
    end
    io.res_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (io.res_valid !== 1'b1 || io.res_data !== 32'd4) begin
      errors++; $display("FAIL bp_second: data=%0d valid=%b want 4/1", io.res_data, io.res_valid);
    end
    @(posedge clock); #1;
    checks++; if (io.res_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: res_valid=%b want 0", io.res_valid); end
  endtask

  task automatic test_reset_mid_chain;
    int n;
    res_log.delete();
    io.res_ready = 1'b1;
    push_cmd(4'd0, 2'b00, 32'd1, 32'd1, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (io.alu_valid !== 1'b0 || io.alu_rready !== 1'b0 || io.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctrl: alu_valid=%b alu_rready=%b cmd_ready=%b want 0/0/0",
                         io.alu_valid, io.alu_rready, io.cmd_ready);
    end
    checks++; if (io.res_valid !== 1'b0 || io.res_data !== 32'd0) begin
      errors++; $display("FAIL mid_rst_res: valid=%b data=%0d want 0/0", io.res_valid, io.res_data);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    push_cmd(4'd3, 2'b00, 32'd8, 32'd1, 1'b1);
    wait_res(n);
    checks++; if (io.res_valid !== 1'b1 || io.res_data !== 32'd9) begin
      errors++; $display("FAIL mid_rst_new: valid=%b data=%0d want 1/9", io.res_valid, io.res_data);
    end
    @(posedge clock); #1;
    checks++; if (res_log.size() != 1) begin errors++; $display("FAIL mid_rst_count: got %0d want 1", res_log.size()); end
  endtask

`ifdef ALU_CHAIN_SEQ_STATS_EN
  task automatic test_stats;
    int n;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    io.res_ready = 1'b1;
    run_dep_chain();
    wait_res(n);
    @(posedge clock); #1;
    checks++; if (stat_ops !== 32'd3) begin errors++; $display("FAIL stat_ops: got %0d want 3", stat_ops); end
    checks++; if (stat_chains !== 32'd1) begin errors++; $display("FAIL stat_chains: got %0d want 1", stat_chains); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; alu_ready_en = 1'b1;
    io.cmd_valid = 1'b0; io.cmd_mode = '0; io.cmd_sel = '0;
    io.cmd_arg1 = '0; io.cmd_arg2 = '0; io.cmd_last = 1'b0;
    io.res_ready = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_single_chain();
    test_dependent_chain();
    test_full_fifo();
    test_backpressure();
    test_reset_mid_chain();
`ifdef ALU_CHAIN_SEQ_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
